// File: rtl/wb_bus_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect: arbiter states,
// cycle/burst type encodings and width helpers for the packed port slices.
package wb_bus_pkg;

   typedef logic [1:0] bus_state_t;

   localparam bus_state_t ST_IDLE = 2'd0;
   localparam bus_state_t ST_BUSY = 2'd1;
   localparam bus_state_t ST_ERR  = 2'd2;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   // Byte-select lanes carried per data word.
   function automatic int sel_width(input int dw);
      return dw / 8;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus-ownership arbiter: latches a one-hot grant when enabled and
// advances the priority pointer past the holder when ownership is released.
module wb_rr_arbiter
   import wb_bus_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   localparam int IW = idx_width(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   enable,
   input  logic                   release_grant,
   output logic [NUM_MASTERS-1:0] grant
);

   localparam logic [IW:0]            NM_W     = (IW+1)'(NUM_MASTERS);
   localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] ptr_next;
   logic [IW:0]   cand;
   logic [IW:0]   inc;
   logic          pick_found;

   // Scan requesters starting at the pointer, wrapping once around the ring.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= NM_W) begin
            cand = cand - NM_W;
         end
         if (!pick_found && req[cand[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      inc      = {1'b0, grant_idx} + 1'b1;
      ptr_next = (inc >= NM_W) ? '0 : inc[IW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else if (release_grant) begin
         grant  <= '0;
         rr_ptr <= ptr_next;
      end else if (enable && pick_found) begin
         grant     <= ONE_HOT0 << pick_idx;
         grant_idx <= pick_idx;
      end
   end

endmodule

// File: rtl/wb_shared_bus.sv
// Multi-master Wishbone shared bus: round-robin ownership, address/mask decode
// to the slaves, error on unmapped addresses and a per-access timeout watchdog.
module wb_shared_bus
   import wb_bus_pkg::*;
#(
   parameter int                        NUM_MASTERS    = 2,
   parameter int                        NUM_SLAVES     = 7,
   parameter int                        AW             = 32,
   parameter int                        DW             = 32,
   parameter logic [NUM_SLAVES*AW-1:0]  SLAVE_ADDR     = '0,
   parameter logic [NUM_SLAVES*AW-1:0]  SLAVE_MASK     = '1,
   parameter int                        TIMEOUT_CYCLES = 255,
   localparam int                       SW             = sel_width(DW)
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,

   input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*SW-1:0]   wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]      wbm_we_i,
   input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
   output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]      wbm_ack_o,
   output logic [NUM_MASTERS-1:0]      wbm_err_o,
   output logic [NUM_MASTERS-1:0]      wbm_rty_o,

   output logic [NUM_SLAVES*AW-1:0]    wbs_adr_o,
   output logic [NUM_SLAVES*DW-1:0]    wbs_dat_o,
   output logic [NUM_SLAVES*SW-1:0]    wbs_sel_o,
   output logic [NUM_SLAVES-1:0]       wbs_we_o,
   output logic [NUM_SLAVES-1:0]       wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]       wbs_stb_o,
   output logic [NUM_SLAVES*3-1:0]     wbs_cti_o,
   output logic [NUM_SLAVES*2-1:0]     wbs_bte_o,
   input  logic [NUM_SLAVES*DW-1:0]    wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]       wbs_ack_i,
   input  logic [NUM_SLAVES-1:0]       wbs_err_i,
   input  logic [NUM_SLAVES-1:0]       wbs_rty_i
);

   localparam int              WDW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);

   bus_state_t             state;
   bus_state_t             state_nxt;
   logic [NUM_MASTERS-1:0] grant;
   logic                   arb_enable;
   logic                   arb_release;

   logic [AW-1:0]          g_adr;
   logic [DW-1:0]          g_dat;
   logic [SW-1:0]          g_sel;
   logic                   g_we;
   logic                   g_cyc;
   logic                   g_stb;
   logic [2:0]             g_cti;
   logic [1:0]             g_bte;

   logic [NUM_SLAVES-1:0]  hit;
   logic                   hit_any;
   logic [DW-1:0]          s_dat;
   logic                   s_ack;
   logic                   s_err;
   logic                   s_rty;
   logic                   s_resp;

   logic [WDW-1:0]         wd_cnt;
   logic                   wd_expire;
   logic                   pass_resp;
   logic                   force_err;

   wb_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_arbiter (
      .clk           (wb_clk_i),
      .rst_n         (wb_rst_ni),
      .req           (wbm_cyc_i),
      .enable        (arb_enable),
      .release_grant (arb_release),
      .grant         (grant)
   );

   // Select the owning master's request; with no owner everything reads zero.
   always_comb begin
      g_adr = '0;
      g_dat = '0;
      g_sel = '0;
      g_we  = 1'b0;
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_cti = '0;
      g_bte = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (grant[m]) begin
            g_adr = wbm_adr_i[m*AW +: AW];
            g_dat = wbm_dat_i[m*DW +: DW];
            g_sel = wbm_sel_i[m*SW +: SW];
            g_we  = wbm_we_i[m];
            g_cyc = wbm_cyc_i[m];
            g_stb = wbm_stb_i[m];
            g_cti = wbm_cti_i[m*3 +: 3];
            g_bte = wbm_bte_i[m*2 +: 2];
         end
      end
   end

   // Lowest-index window wins when slave windows overlap.
   always_comb begin
      hit     = '0;
      hit_any = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!hit_any &&
             ((g_adr & SLAVE_MASK[i*AW +: AW]) ==
              (SLAVE_ADDR[i*AW +: AW] & SLAVE_MASK[i*AW +: AW]))) begin
            hit[i]  = 1'b1;
            hit_any = 1'b1;
         end
      end
   end

   always_comb begin
      s_dat = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      s_rty = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (hit[i]) begin
            s_dat = wbs_dat_i[i*DW +: DW];
            s_ack = wbs_ack_i[i];
            s_err = wbs_err_i[i];
            s_rty = wbs_rty_i[i];
         end
      end
      s_resp = s_ack | s_err | s_rty;
   end

   assign wd_expire  = hit_any && !s_resp && (wd_cnt == WD_LIMIT);
   assign arb_enable = (state == ST_IDLE);

   always_comb begin
      state_nxt   = state;
      arb_release = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|wbm_cyc_i) begin
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!g_cyc) begin
               state_nxt   = ST_IDLE;
               arb_release = 1'b1;
            end else if (g_stb && (!hit_any || wd_expire)) begin
               state_nxt = ST_ERR;
            end
         end
         ST_ERR: begin
            if (!g_cyc) begin
               state_nxt   = ST_IDLE;
               arb_release = 1'b1;
            end else begin
               state_nxt = ST_BUSY;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Counts cycles a mapped strobe has waited; any response or idle strobe restarts it.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wd_cnt <= '0;
      end else if ((state != ST_BUSY) || !g_stb || !hit_any || s_resp) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wbs_adr_o = {NUM_SLAVES{g_adr}};
   assign wbs_dat_o = {NUM_SLAVES{g_dat}};
   assign wbs_sel_o = {NUM_SLAVES{g_sel}};
   assign wbs_we_o  = {NUM_SLAVES{g_we}};
   assign wbs_cti_o = {NUM_SLAVES{g_cti}};
   assign wbs_bte_o = {NUM_SLAVES{g_bte}};
   assign wbs_cyc_o = ((state != ST_IDLE) && g_cyc) ? hit : '0;
   assign wbs_stb_o = ((state == ST_BUSY) && g_cyc && g_stb) ? hit : '0;

   assign pass_resp = (state == ST_BUSY) && g_cyc && hit_any;
   assign force_err = (state == ST_ERR) && g_cyc;

   always_comb begin
      wbm_dat_o = '0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (grant[m]) begin
            if (pass_resp) begin
               wbm_dat_o[m*DW +: DW] = s_dat;
               wbm_ack_o[m]          = s_ack;
               wbm_err_o[m]          = s_err;
               wbm_rty_o[m]          = s_rty;
            end else if (force_err) begin
               wbm_err_o[m] = 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/wb_shared_bus.md
# wb_shared_bus

Parametrised multi-master Wishbone B4 (classic and registered-feedback tolerant) shared-bus interconnect for the SoC fabric: arbitrates NUM_MASTERS initiators (e.g. instruction fetch, data port, debug/DMA) onto one bus and decodes it to NUM_SLAVES targets via address/mask pairs. It supersedes the fixed single-master 7-slave mux. It adds round-robin arbitration, an error response for unmapped addresses, and a per-access timeout watchdog so a hung peripheral cannot stall the core.

## Interface
- NUM_MASTERS, 2, initiators (1..8)
- NUM_SLAVES, 7, targets (1..16)
- AW, 32, address width; DW, 32, data width (SEL width DW/8)
- SLAVE_ADDR, {NUM_SLAVES{AW'0}}, packed match addresses, slave i at bits [i*AW +: AW]
- SLAVE_MASK, {NUM_SLAVES{AW'1}}, packed masks, same packing
- TIMEOUT_CYCLES, 255, stb-without-response cycles before forced err (>=2)
- wb_clk_i  in  1  bus clock; sole clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  NUM_MASTERS×{AW,DW,DW/8,1,1,1,3,2}  packed master requests, master m at slice m
- wbm_dat_o/ack_o/err_o/rty_o  out  NUM_MASTERS×{DW,1,1,1}  per-master responses
- wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  NUM_SLAVES×{AW,DW,DW/8,1,1,1,3,2}  per-slave requests
- wbs_dat_i/ack_i/err_i/rty_i  in  NUM_SLAVES×{DW,1,1,1}  per-slave responses

## Operation
- Arbiter FSM: IDLE, BUSY, ERR. IDLE: if any wbm_cyc_i, grant registers to first requester at or after rr_ptr (wrapping), -> BUSY. BUSY: hold grant while granted cyc high; on granted cyc low -> IDLE, rr_ptr <= grant+1 mod NUM_MASTERS. ERR: entered from BUSY on unmapped access or timeout; drives err one cycle, then -> BUSY (grant kept).
- Decode: combinational on granted master's adr; slave i matches when (adr & MASK_i) == (ADDR_i & MASK_i); lowest index wins on overlap. Only matched slave sees cyc/stb; adr/dat/sel/we/cti/bte broadcast to all slaves.
- Unmapped: granted stb high with no match -> ERR; no slave cyc asserted.
- Watchdog: counter clears on grant change, on stb low, or on any slave ack/err/rty; increments while granted stb high and no response; at TIMEOUT_CYCLES-1 -> ERR, slave stb suppressed during ERR cycle.
- Response routing: matched slave's dat/ack/err/rty passed combinationally to granted master only; non-granted masters see all zero. In ERR only err_o of granted master high, dat_o zero.

## Timing
- Reset: all outputs 0, FSM IDLE, grant none, rr_ptr 0, counter 0.
- Grant latency: 1 cycle from cyc_i to slave cyc/stb; ack-to-master is 0-cycle (combinational).
- Back-to-back ownership change costs exactly one IDLE cycle.
- Unmapped err: err_o high on the cycle after stb first seen, exactly one cycle per access.
- Timeout err: asserted TIMEOUT_CYCLES cycles after stb first reaches the slave.
- Simultaneous requests: rr_ptr order; holder never preempted.
- Granted master dropping cyc during ERR: FSM -> IDLE, err not issued.
- Reset asserted mid-transfer: outputs clear asynchronously; no partial state survives.

## Structure
- wb_bus_pkg: fsm state enum, cti/bte constants, helper for packed-slice width.
- Sub-module wb_rr_arbiter (NUM_MASTERS, req vector, enable, grant one-hot, rr_ptr); decode and watchdog inline.

## Test plan
- Bench params: NUM_MASTERS=2, NUM_SLAVES=3, ADDR {0x20000000,0x10000000,0x00000000}, MASK {0xFFFFFF00,0xFFFF8000,0xFFFE0000}, TIMEOUT_CYCLES=16.
- M0 read 0x00000010, slave 0 acks after 2 cycles with 0xDEADBEEF -> only wbs_cyc_o[0] high, M0 gets dat 0xDEADBEEF + 1-cycle ack, M1 outputs 0.
- M0 and M1 raise cyc same cycle after reset -> M0 granted first; M0 drops cyc -> one idle cycle, M1 granted.
- M1 write 0x30000000 -> no slave cyc, M1 err_o one cycle 1 cycle after stb.
- M0 read 0x20000004, slave 2 never responds -> err_o after 16 cycles, slave stb low that cycle.
- Overlap: ADDR1=ADDR0, adr 0x10000000 -> slave 0 selected.
- wb_rst_ni low mid-burst -> all outputs 0 same cycle; post-reset M1 request granted (rr_ptr 0 but M0 idle).
